// File: rtl/gcd_engine.sv
// gcd_engine: multi-cycle GCD (subtractive by default, binary/Stein when GCD_ENGINE_STEIN_EN is defined).
// Every output is driven straight from a flop; done trails the DONE state by one cycle.
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] iter_count,
    output logic             err_zero
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0] a, b, a_d, b_d, res_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc, it_d;
    logic err_d;
    assign cnt_inc = &cnt ? cnt : cnt + CNT_W'(1);
`ifdef GCD_ENGINE_STEIN_EN
    localparam int KW = $clog2(WIDTH) + 1;
    logic [KW-1:0] k, k_d;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) k <= '0;
        else k <= k_d;
`endif
    always_comb begin
        state_d = state;
        a_d     = a;
        b_d     = b;
        cnt_d   = cnt;
        res_d   = gcd_out;
        it_d    = iter_count;
        err_d   = err_zero;
`ifdef GCD_ENGINE_STEIN_EN
        k_d     = k;
`endif
        case (state)
            S_IDLE: if (start) begin
                a_d   = a_in;
                b_d   = b_in;
                cnt_d = '0;
`ifdef GCD_ENGINE_STEIN_EN
                k_d   = '0;
`endif
                if (a_in == '0 || b_in == '0) begin
                    state_d = S_DONE;
                    res_d   = a_in | b_in;
                    it_d    = '0;
                    err_d   = (a_in | b_in) == '0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: if (a == b) begin
                state_d = S_DONE;
                it_d    = cnt;
                err_d   = 1'b0;
`ifdef GCD_ENGINE_STEIN_EN
                res_d   = a << k;
`else
                res_d   = a;
`endif
            end else begin
                cnt_d = cnt_inc;
`ifdef GCD_ENGINE_STEIN_EN
                // common factors of two are stripped together and restored via k
                if (!a[0] && !b[0]) begin
                    a_d = a >> 1;
                    b_d = b >> 1;
                    k_d = k + KW'(1);
                end else if (!a[0]) a_d = a >> 1;
                else if (!b[0]) b_d = b >> 1;
                else if (a > b) a_d = (a - b) >> 1;
                else b_d = (b - a) >> 1;
`else
                a_d = a > b ? a - b : a;
                b_d = a > b ? b : b - a;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= S_IDLE;
            a          <= '0;
            b          <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gcd_out    <= '0;
            iter_count <= '0;
            err_zero   <= 1'b0;
        end else begin
            state      <= state_d;
            a          <= a_d;
            b          <= b_d;
            cnt        <= cnt_d;
            busy       <= state_d != S_IDLE;
            done       <= state == S_DONE;
            gcd_out    <= res_d;
            iter_count <= it_d;
            err_zero   <= err_d;
        end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: scoreboard bench; the Euclid-quotient reference model predicts result, count and latency.
module tb_gcd_engine;
    localparam int W  = 16;
    localparam int CW = 8;
    typedef struct {
        logic [W-1:0]  g;
        logic [CW-1:0] it;
        logic          ez;
        longint        lat;
    } exp_t;
    logic clk = 0, rst_n = 0, start = 0;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic busy, done, err_zero;
    logic [W-1:0] gcd_out;
    logic [CW-1:0] iter_count;
    exp_t q[$];
    longint cyc = 0;
    int n_chk = 0, n_err = 0;

    gcd_engine #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .gcd_out(gcd_out), .iter_count(iter_count), .err_zero(err_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // subtraction count = sum of Euclid quotients minus one; latency is count + 2
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint x = a, y = b, r, n = 0;
        if (x == 0 || y == 0) begin
            e.g = (x == 0) ? W'(y) : W'(x);
            e.ez = (x == 0 && y == 0);
            e.it = '0;
            e.lat = 1;
        end else begin
            while (y != 0) begin
                n += x / y;
                r = x % y;
                x = y;
                y = r;
            end
            n -= 1;
            e.g = W'(x);
            e.ez = 1'b0;
            e.it = (n > 255) ? 8'd255 : CW'(n);
            e.lat = n + 2;
        end
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL spurious_done: got done=1 required no pending result");
            end else begin
                e = q.pop_front();
                chk("gcd_out", 64'(gcd_out), 64'(e.g));
                chk("err_zero", 64'(err_zero), 64'(e.ez));
`ifdef GCD_ENGINE_STEIN_EN
                chk("latency_bound", 64'(cyc - e.lat + e.lat <= e.lat + 2 * W + 2), 64'd1);
`else
                chk("iter_count", 64'(iter_count), 64'(e.it));
                chk("latency", 64'(cyc), 64'(e.lat));
`endif
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e = model(a, b);
        @(negedge clk);
        a_in = a;
        b_in = b;
        start = 1;
        @(posedge clk);
        #1;
`ifdef GCD_ENGINE_STEIN_EN
        e.lat = cyc;
`else
        e.lat += cyc;
`endif
        q.push_back(e);
        start = 0;
        a_in = W'($urandom);
        b_in = W'($urandom);
    endtask

    task automatic wait_idle(input int lim);
        int i = 0;
        while ((busy || q.size() != 0) && i < lim) begin
            @(negedge clk);
            i++;
        end
        if (busy || q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: got no done within %0d cycles required done", lim);
            q.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int lim);
        issue(a, b);
        wait_idle(lim);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_gcd", 64'(gcd_out), 0);
        chk("rst_iter", 64'(iter_count), 0);
        chk("rst_err", 64'(err_zero), 0);
        rst_n = 1;
        run(143, 78, 100);
        run(0, 25, 20);
        run(25, 0, 20);
        run(0, 0, 20);
        run(1000, 1, 1200);
        run(65535, 1, 70000);
        issue(48, 18);
        @(negedge clk);
        start = 1;
        a_in = 100;
        b_in = 7;
        @(negedge clk);
        chk("busy_in_run", 64'(busy), 1);
        start = 0;
        wait_idle(50);
        repeat (5) @(negedge clk);
        chk("no_second_run", 64'(busy), 0);
        @(negedge clk);
        a_in = 1000;
        b_in = 3;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("busy_before_rst", 64'(busy), 1);
        rst_n = 0;
        #1;
        chk("arst_busy", 64'(busy), 0);
        chk("arst_gcd", 64'(gcd_out), 0);
        chk("arst_iter", 64'(iter_count), 0);
        chk("arst_err", 64'(err_zero), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("quiet_after_rst", 64'(busy), 0);
        run(12, 8, 50);
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
            b = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 255));
            run(a, b, 400);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
